// File: rtl/tff_pkg.sv
// Shared definitions for the toggle flip-flop bank: reset value and the
// per-bit override priority used by checkers.
package tff_pkg;

   localparam logic Q_RESET = 1'b0;

   // Highest priority first; exactly one applies to a bit at any instant.
   typedef enum logic [2:0] {
      RST    = 3'd0,
      CLR    = 3'd1,
      PRS    = 3'd2,
      TOGGLE = 3'd3,
      HOLD   = 3'd4
   } prio_e;

   function automatic prio_e override_prio(input logic rst,
                                           input logic clr_b,
                                           input logic prs_b,
                                           input logic t);
      if (rst)         return RST;
      else if (!clr_b) return CLR;
      else if (!prs_b) return PRS;
      else if (t)      return TOGGLE;
      else             return HOLD;
   endfunction

endpackage

// File: rtl/tff_cell.sv
// One toggle cell with asynchronous reset, clear and preset overrides and a
// complementary output derived from the same state bit.
module tff_cell
   import tff_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic t,
   input  logic prs_b,
   input  logic clr_b,
   output logic q,
   output logic q_b
);

   logic w_force_0;
   logic w_force_1;
   logic r_q;

   // The three overrides collapse into two ordered force lines. Releasing a
   // higher-priority override while preset is still held raises w_force_1,
   // which re-triggers the flop and loads the preset value immediately.
   assign w_force_0 = rst | ~clr_b;
   assign w_force_1 = ~prs_b & ~w_force_0;

   // NOTE: state updates use non-blocking assignments so every cell samples
   // its inputs before any cell's state changes on the same edge.
   always_ff @(posedge clk or posedge w_force_0 or posedge w_force_1) begin
      if (w_force_0)
         r_q <= Q_RESET;
      else if (w_force_1)
         r_q <= ~Q_RESET;
      else if (t)
         r_q <= ~r_q;
   end

   assign q   = r_q;
   assign q_b = ~r_q;

endmodule

// File: rtl/tff.sv
// Bank of WIDTH independent toggle flip-flops sharing one clock, with per-bit
// asynchronous clear/preset and a common asynchronous reset.
module tff
   import tff_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   input  logic [WIDTH-1:0] prs_b,
   input  logic [WIDTH-1:0] clr_b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_b
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
         .clk   (clk),
         .rst   (rst),
         .t     (t[i]),
         .prs_b (prs_b[i]),
         .clr_b (clr_b[i]),
         .q     (q[i]),
         .q_b   (q_b[i])
      );

      // Forced values must hold for as long as the override is applied.
      a_force_0 : assert property (@(negedge clk)
         (override_prio(rst, clr_b[i], prs_b[i], t[i]) inside {RST, CLR}) |-> !q[i]);
      a_force_1 : assert property (@(negedge clk)
         (override_prio(rst, clr_b[i], prs_b[i], t[i]) == PRS) |-> q[i]);
   end

   a_complement : assert property (@(negedge clk) q_b == ~q);
   a_clear      : assert property (@(negedge clk)
      (q & ({WIDTH{rst}} | ~clr_b)) == '0);
   a_preset     : assert property (@(negedge clk)
      (~q & ~prs_b & clr_b & ~{WIDTH{rst}}) == '0);

endmodule

// File: tb/tb_tff.sv
// Self-checking bench for tff (WIDTH=1): directed scenarios followed by
// randomized toggles and overrides, checked against a behavioural model.
module tb_tff;

   logic clk = 1'b0;
   logic rst;
   logic [0:0] t;
   logic [0:0] prs_b;
   logic [0:0] clr_b;
   logic [0:0] q;
   logic [0:0] q_b;

   int   n_cmp  = 0;
   int   n_fail = 0;
   logic m_q    = 1'b0;   // model of the stored bit
   bit   m_live = 1'b0;

   tff #(.WIDTH(1)) dut (
      .clk   (clk),
      .rst   (rst),
      .t     (t),
      .prs_b (prs_b),
      .clr_b (clr_b),
      .q     (q),
      .q_b   (q_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Value an override forces, or the current value when none is active.
   function automatic logic forced(input logic cur);
      if (rst || !clr_b[0]) return 1'b0;
      if (!prs_b[0])        return 1'b1;
      return cur;
   endfunction

   // Apply an asynchronous input change to the model, then check it.
   task automatic poke(input logic r, input logic p, input logic c, input string name);
      rst = r; prs_b[0] = p; clr_b[0] = c;
      m_q = forced(m_q);
      #1;
      check({name, "_q"},  q[0],   m_q);
      check({name, "_qb"}, q_b[0], ~m_q);
   endtask

   // Drive inputs 1 unit before the next rising edge, then update the model.
   task automatic step(input logic tv, input logic p, input logic c, input logic r);
      @(negedge clk);
      #4;
      t[0] = tv; prs_b[0] = p; clr_b[0] = c; rst = r;
      m_q = forced(m_q);
      @(posedge clk);
      #1;
      if (!rst && clr_b[0] && prs_b[0] && t[0]) m_q = ~m_q;
   endtask

   always @(negedge clk) begin
      if (m_live) begin
         check("cyc_q",  q[0],   m_q);
         check("cyc_qb", q_b[0], ~m_q);
      end
   end

   initial begin
      logic [2:0] sel;
      logic       tv, p, c, r;
      logic [0:0] exp_seq [7];

      // Reset at time 0, any t.
      clr_b = 1'b1; prs_b = 1'b1; t = 1'b1; rst = 1'b1;
      #1;
      check("reset_q",  q[0],   1'b0);
      check("reset_qb", q_b[0], 1'b1);
      m_q    = 1'b0;
      m_live = 1'b1;

      // Release reset with t=0: q stays 0 for three edges.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0);
         check("post_reset_hold", q[0], 1'b0);
      end

      // Async overrides without a clock edge.
      poke(1'b0, 1'b1, 1'b0, "async_clr");
      check("async_clr_lit", q[0], 1'b0);
      poke(1'b0, 1'b0, 1'b1, "async_prs");
      check("async_prs_lit", q[0], 1'b1);
      poke(1'b0, 1'b0, 1'b0, "async_clr_again");
      check("async_clr_again_lit", q[0], 1'b0);
      check("both_low_qb", q_b[0], 1'b1);

      // Toggle/hold: t = 0,1,0,1 -> q = 0,1,1,0.
      exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b1; exp_seq[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(logic'(i % 2), 1'b1, 1'b1, 1'b0);
         check("toggle_seq", q[0], exp_seq[i][0]);
      end

      // Preset dominance, then clear dominance, with t=1.
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         check("prs_dominates", q[0], 1'b1);
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         check("clr_dominates", q[0], 1'b0);
      end

      // Resume after release: t = 0,1,0,1,0,1,0 -> q = 0,1,1,0,0,1,1.
      exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b1; exp_seq[3] = 1'b0;
      exp_seq[4] = 1'b0; exp_seq[5] = 1'b1; exp_seq[6] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step(logic'(i % 2), 1'b1, 1'b1, 1'b0);
         check("resume_seq", q[0], exp_seq[i][0]);
      end

      // Reset mid-toggle with t=1: immediate, and held while asserted.
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("pre_rst_toggle", q[0], 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("pre_rst_toggle2", q[0], 1'b1);
      poke(1'b1, 1'b1, 1'b1, "rst_mid");
      check("rst_mid_lit", q[0], 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b1);
         check("rst_held", q[0], 1'b0);
      end

      // Randomized toggles, clock-aligned overrides and mid-cycle pulses.
      for (int n = 0; n < 400; n++) begin
         tv  = 1'(($urandom_range(0, 1)));
         sel = 3'($urandom_range(0, 7));
         r = 1'b0; p = 1'b1; c = 1'b1;
         case (sel)
            3'd0: c = 1'b0;
            3'd1: p = 1'b0;
            3'd2: begin c = 1'b0; p = 1'b0; end
            3'd3: r = 1'b1;
            default: ;
         endcase
         step(tv, p, c, r);
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 2))
               0:       poke(1'b1, p, c, "rnd_pulse_rst");
               1:       poke(r, 1'b0, c, "rnd_pulse_prs");
               default: poke(r, p, 1'b0, "rnd_pulse_clr");
            endcase
            poke(r, p, c, "rnd_pulse_release");
         end
      end

      step(1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
